seq_magnitude_comparator: RTL
=============================

Name: seq_magnitude_comparator

Overview:
Parametrised, multi-cycle magnitude comparator for WIDTH-bit operands. It scans DIGIT bits per clock, most significant digit first, and supports unsigned or two's-complement signed compare. Operands enter through a valid/ready handshake and the registered A>B / A<B / A=B result leaves through a second handshake. It serves datapaths where WIDTH is too wide for a single-cycle comparator tree.

Parameters:
WIDTH, 16, operand width in bits; must be a multiple of DIGIT and at least DIGIT.
DIGIT, 4, bits compared per cycle. NDIG = WIDTH/DIGIT is the number of compare cycles.

Ports:
clock  input  1  rising-edge clock
reset_n  input  1  asynchronous, active-low reset
in_valid  input  1  operands A, B and signed_mode are valid
in_ready  output  1  block can accept operands (high only in IDLE)
A  input  WIDTH  operand A
B  input  WIDTH  operand B
signed_mode  input  1  1 = two's-complement compare, 0 = unsigned
out_valid  output  1  result valid; held until out_ready
out_ready  input  1  consumer accepts the result
A_gt_B  output  1  registered result: A > B
A_lt_B  output  1  registered result: A < B
A_eq_B  output  1  registered result: A == B

Behaviour:
- One clock domain (clock). reset_n is asynchronous, active-low.
- Reset values: state IDLE, in_ready=1 after reset is released, out_valid=0, A_gt_B=A_lt_B=A_eq_B=0, shift registers=0, digit counter=0.
- States:
  - IDLE: in_ready=1. On the in_valid&&in_ready edge, latch A and B into shift registers. If signed_mode=1, invert bit WIDTH-1 of both latched operands, so an unsigned compare gives the signed result. Clear the result flags, counter=0, go to COMPARE.
  - COMPARE: in_ready=0. Each cycle, the top DIGIT bits of both registers feed cmp_digit. Unequal digit: register gt/lt from the digit compare (eq=0); with early exit compiled out, stop updating but keep stepping until all digits are scanned. Equal digit: shift both registers left by DIGIT and increment the counter. After digit NDIG-1 with every digit equal, register eq=1. When the scan completes, go to DONE.
  - DONE: out_valid=1, flags stable. On out_valid&&out_ready, clear out_valid and go to IDLE. The flags keep their value until the next accept.
- Latency without early exit: accept on edge k gives out_valid high after edge k+NDIG, for every operand pair.
- When out_valid=1, exactly one of gt/lt/eq is 1. Before the first result after reset, all three are 0.
- in_valid while not IDLE is ignored; the operands are not captured. The producer must hold them until in_ready.
- out_ready while out_valid=0 has no effect.
- Backpressure: DONE persists any number of cycles. Throughput is at most one compare per NDIG+2 cycles, because DONE->IDLE costs one cycle.
- reset_n low mid-COMPARE or mid-DONE: immediate return to reset values; the pending result is discarded.
- Boundary values are compared exactly:
  - All-zeros vs all-ones: unsigned gives lt; signed gives gt (0 > -1).
  - Most-negative vs most-positive signed: lt.

Optional Feature:
Macro SEQ_CMP_EARLY_EXIT_EN.
- Defined: COMPARE moves to DONE on the same edge that registers the first unequal digit. If the first differing digit has index i (0 = most significant), out_valid rises after edge k+i+1. Equal operands still take NDIG cycles.
- Undefined: fixed NDIG-cycle latency as above, for constant-time use.

Decomposition:
- Shared package/include seq_cmp_pkg holds:
  - state encoding constants: IDLE=2'd0, COMPARE=2'd1, DONE=2'd2
  - the NDIG derivation
  - a WIDTH%DIGIT legality check (elaboration error when violated)
- Sub-module cmp_digit(gt, lt, eq, a, b), parameter W=DIGIT: purely combinational. Per-bit equality terms are ANDed down the MSB-first prefix chain to form gt/lt, with eq as the reduction AND of the equality terms. Instantiated once.
- FSM, counter and shift registers live in the top module (roughly 150-250 lines).

Test Plan:
- Defaults, unsigned, A=16'h1234, B=16'h1234, out_ready=1 -> out_valid after exactly 4 cycles, A_eq_B=1, others 0.
- Unsigned, A=16'h8000, B=16'h7FFF -> A_gt_B=1. Signed, same values -> A_lt_B=1. Signed, A=16'hFFFF, B=16'h0000 -> A_lt_B=1.
- With SEQ_CMP_EARLY_EXIT_EN, A=16'h5000, B=16'h4FFF -> out_valid 1 cycle after accept, A_gt_B=1. Without the macro -> 4 cycles, same result.
- Backpressure: out_ready=0 for 10 cycles in DONE, in_valid=1 with new operands -> in_ready=0, flags stable, new operands ignored. Raise out_ready -> IDLE next cycle, then the new pair is accepted.
- reset_n pulsed low during COMPARE (digit 2) -> out_valid=0, all flags 0, in_ready=1 after release. The next compare A=16'h0001, B=16'h0002 -> A_lt_B=1.
- WIDTH=8, DIGIT=1: random sweep of 1000 unsigned and signed pairs checked against a golden model. Latency is 8 cycles with the macro undefined.

Source files
------------

// File: rtl/seq_cmp_pkg.sv
// Shared types and elaboration helpers for the digit-serial magnitude comparator.
// Optional early exit is selected with the SEQ_CMP_EARLY_EXIT_EN macro in the top module.
package seq_cmp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COMPARE = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

  // Number of compare cycles for a given operand and digit width.
  function automatic int unsigned calc_ndig(input int unsigned width, input int unsigned digit);
    return width / digit;
  endfunction

  // Operands must split into a whole number of digits.
  function automatic bit width_legal(input int unsigned width, input int unsigned digit);
    return (digit != 0) && (width >= digit) && ((width % digit) == 0);
  endfunction

endpackage

// File: rtl/cmp_digit.sv
// Combinational magnitude compare of one W-bit digit, MSB-first prefix chain.
module cmp_digit #(
  parameter int unsigned W = 4
) (
  output logic         gt,
  output logic         lt,
  output logic         eq,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b
);

  logic prefix_eq;

  // A bit decides only if every more significant bit pair was equal.
  always_comb begin
    gt        = 1'b0;
    lt        = 1'b0;
    prefix_eq = 1'b1;
    for (int i = int'(W) - 1; i >= 0; i--) begin
      gt        = gt | (prefix_eq & a[i] & ~b[i]);
      lt        = lt | (prefix_eq & ~a[i] & b[i]);
      prefix_eq = prefix_eq & ~(a[i] ^ b[i]);
    end
    eq = &(~(a ^ b));
  end

endmodule

// File: rtl/seq_magnitude_comparator.sv
// Digit-serial WIDTH-bit magnitude comparator with valid/ready in and out handshakes.
// Define SEQ_CMP_EARLY_EXIT_EN to finish on the first unequal digit instead of after NDIG cycles.
module seq_magnitude_comparator
  import seq_cmp_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DIGIT = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             signed_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             A_gt_B,
  output logic             A_lt_B,
  output logic             A_eq_B
);

  localparam int unsigned NDIG  = calc_ndig(WIDTH, DIGIT);
  localparam int unsigned CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;

  if (!width_legal(WIDTH, DIGIT)) begin : g_illegal_width
    $error("seq_magnitude_comparator: WIDTH must be a non-zero multiple of DIGIT");
  end

  state_t             state_q, state_n;
  logic [WIDTH-1:0]   a_sh_q, a_sh_n;
  logic [WIDTH-1:0]   b_sh_q, b_sh_n;
  logic [CNT_W-1:0]   cnt_q, cnt_n;
  logic               decided_q, decided_n;
  logic               in_ready_n;
  logic               out_valid_n;
  logic               gt_n, lt_n, eq_n;
  logic [WIDTH-1:0]   a_ld, b_ld;
  logic               dig_gt, dig_lt, dig_eq;

  cmp_digit #(
    .W (DIGIT)
  ) u_cmp_digit (
    .gt (dig_gt),
    .lt (dig_lt),
    .eq (dig_eq),
    .a  (a_sh_q[WIDTH-1 -: DIGIT]),
    .b  (b_sh_q[WIDTH-1 -: DIGIT])
  );

  // Flipping both sign bits maps two's-complement order onto unsigned order.
  always_comb begin
    a_ld = A;
    b_ld = B;
    if (signed_mode) begin
      a_ld[WIDTH-1] = ~A[WIDTH-1];
      b_ld[WIDTH-1] = ~B[WIDTH-1];
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_n     = state_q;
    a_sh_n      = a_sh_q;
    b_sh_n      = b_sh_q;
    cnt_n       = cnt_q;
    decided_n   = decided_q;
    out_valid_n = out_valid;
    gt_n        = A_gt_B;
    lt_n        = A_lt_B;
    eq_n        = A_eq_B;

    unique case (state_q)
      ST_IDLE: begin
        if (in_valid && in_ready) begin
          a_sh_n    = a_ld;
          b_sh_n    = b_ld;
          cnt_n     = '0;
          decided_n = 1'b0;
          gt_n      = 1'b0;
          lt_n      = 1'b0;
          eq_n      = 1'b0;
          state_n   = ST_COMPARE;
        end
      end

      ST_COMPARE: begin
        a_sh_n = a_sh_q << DIGIT;
        b_sh_n = b_sh_q << DIGIT;
        cnt_n  = cnt_q + CNT_W'(1);
        // First unequal digit fixes the answer; later digits are ignored.
        if (!dig_eq && !decided_q) begin
          gt_n      = dig_gt;
          lt_n      = dig_lt;
          decided_n = 1'b1;
`ifdef SEQ_CMP_EARLY_EXIT_EN
          state_n     = ST_DONE;
          out_valid_n = 1'b1;
`endif
        end
        if (cnt_q == CNT_W'(NDIG - 1)) begin
          if (dig_eq && !decided_q) begin
            eq_n = 1'b1;
          end
          state_n     = ST_DONE;
          out_valid_n = 1'b1;
        end
      end

      ST_DONE: begin
        if (out_ready) begin
          out_valid_n = 1'b0;
          state_n     = ST_IDLE;
        end
      end

      default: begin
        state_n     = ST_IDLE;
        out_valid_n = 1'b0;
      end
    endcase

    in_ready_n = (state_n == ST_IDLE);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      a_sh_q    <= '0;
      b_sh_q    <= '0;
      cnt_q     <= '0;
      decided_q <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      A_gt_B    <= 1'b0;
      A_lt_B    <= 1'b0;
      A_eq_B    <= 1'b0;
    end else begin
      state_q   <= state_n;
      a_sh_q    <= a_sh_n;
      b_sh_q    <= b_sh_n;
      cnt_q     <= cnt_n;
      decided_q <= decided_n;
      in_ready  <= in_ready_n;
      out_valid <= out_valid_n;
      A_gt_B    <= gt_n;
      A_lt_B    <= lt_n;
      A_eq_B    <= eq_n;
    end
  end

endmodule
